// File: rtl/sb_pkg.sv
// sb_pkg: shared sideband framing constants, types and bytewise CRC-16 helper
package sb_pkg;
  localparam logic [7:0] DLE     = 8'hFE;
  localparam logic [7:0] ETX     = 8'h40;
  localparam logic [7:0] STX_CMD = 8'h05;
  localparam logic [7:0] STX_RSP = 8'h04;
  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  typedef enum logic [1:0] {AT_CMD = 2'd0, AT_RSP = 2'd1, LT = 2'd2} sb_tr_type_e;
  typedef enum logic [2:0] {IDLE, START, AT_DATA, AT_DLE, LT_CLSE, LT_DLE, LT_ETX} sb_state_e;
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/sb_crc16.sv
// sb_crc16: running CRC-16 register, seeded from the STX byte and advanced per stored byte
module sb_crc16 import sb_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);
  logic [15:0] r_crc;
  assign o_crc = r_crc;
  // start restarts from the init value folded with this byte; enable folds in one more byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_crc <= '0;
    else if (i_start) r_crc <= crc16_byte(CRC_INIT, i_byte);
    else if (i_en) r_crc <= crc16_byte(r_crc, i_byte);
endmodule

// File: rtl/sb_rx_deframer.sv
// sb_rx_deframer: sideband RX deframer (DLE unstuffing, AT CRC check, LT validation); SB_TIMEOUT_EN adds an inter-byte timeout
module sb_rx_deframer import sb_pkg::*; #(
  parameter int MAX_BYTES   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_rx_valid,
  input  logic [7:0]                   i_rx_byte,
  output logic                         o_tr_valid,
  output logic [1:0]                   o_tr_type,
  output logic [8*MAX_BYTES-1:0]       o_tr_data,
  output logic [$clog2(MAX_BYTES+1)-1:0] o_tr_len,
  output logic                         o_crc_err,
  output logic                         o_frame_err
);
  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam int CW = $clog2(MAX_BYTES + 3);
  sb_state_e r_state, w_next;
  sb_tr_type_e r_type;
  logic [8*MAX_BYTES-1:0] r_buf, w_payload;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_lse;
  logic [15:0] w_crc;
  logic w_store, w_crc_start, w_lt_start, w_ok, w_cerr, w_ferr, w_timeout;

  sb_crc16 u_crc (
    .clk(clk), .rst_n(rst_n), .i_start(w_crc_start), .i_en(w_store),
    .i_byte(i_rx_byte), .o_crc(w_crc)
  );

`ifdef SB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_idle;
  // counts quiet cycles inside a frame; any byte or a return to IDLE restarts it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_idle <= '0;
    else r_idle <= (i_rx_valid || r_state == IDLE) ? '0 : r_idle + 1'b1;
  assign w_timeout = r_state != IDLE && !i_rx_valid && r_idle == TW'(TIMEOUT_CYC - 1);
`else
  assign w_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // next state and per-byte actions; a store past the CRC slots aborts the frame
  always_comb begin
    w_next = r_state;
    w_store = 1'b0;
    w_crc_start = 1'b0;
    w_lt_start = 1'b0;
    w_ok = 1'b0;
    w_cerr = 1'b0;
    w_ferr = 1'b0;
    if (w_timeout) begin
      w_next = IDLE;
      w_ferr = 1'b1;
    end else if (i_rx_valid) begin
      case (r_state)
        IDLE: w_next = i_rx_byte == DLE ? START : IDLE;
        START:
          if (i_rx_byte == STX_CMD || i_rx_byte == STX_RSP) begin
            w_next = AT_DATA;
            w_crc_start = 1'b1;
          end else if (i_rx_byte == DLE) w_ferr = 1'b1;
          else begin
            w_next = LT_CLSE;
            w_lt_start = 1'b1;
          end
        AT_DATA: begin
          w_next = i_rx_byte == DLE ? AT_DLE : AT_DATA;
          w_store = i_rx_byte != DLE;
        end
        AT_DLE:
          if (i_rx_byte == DLE) begin
            w_next = AT_DATA;
            w_store = 1'b1;
          end else begin
            w_next = IDLE;
            w_ferr = i_rx_byte != ETX || r_cnt < CW'(2);
            w_cerr = i_rx_byte == ETX && r_cnt >= CW'(2) && w_crc != 16'h0;
            w_ok = i_rx_byte == ETX && r_cnt >= CW'(2) && w_crc == 16'h0;
          end
        LT_CLSE: begin
          w_next = i_rx_byte == ~r_lse ? LT_DLE : IDLE;
          w_ferr = i_rx_byte != ~r_lse;
        end
        LT_DLE: begin
          w_next = i_rx_byte == DLE ? LT_ETX : IDLE;
          w_ferr = i_rx_byte != DLE;
        end
        LT_ETX: begin
          w_next = IDLE;
          w_ok = i_rx_byte == ETX;
          w_ferr = i_rx_byte != ETX;
        end
        default: w_next = IDLE;
      endcase
    end
    if (w_store && r_cnt == CW'(MAX_BYTES + 2)) begin
      w_store = 1'b0;
      w_ferr = 1'b1;
      w_next = IDLE;
    end
  end

  // payload view: stored bytes minus the trailing two CRC bytes, the rest zero
  always_comb begin
    w_payload = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (CW'(i) + CW'(2) < r_cnt) w_payload[8*i +: 8] = r_buf[8*i +: 8];
  end

  // frame context: type, LSE and de-stuffed byte buffer (CRC bytes only counted, never needed)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_type <= AT_CMD;
      r_lse <= '0;
      r_cnt <= '0;
      r_buf <= '0;
    end else begin
      if (w_crc_start) begin
        r_cnt <= '0;
        r_type <= i_rx_byte == STX_CMD ? AT_CMD : AT_RSP;
      end
      if (w_lt_start) begin
        r_lse <= i_rx_byte;
        r_type <= LT;
      end
      if (w_store) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt < CW'(MAX_BYTES)) r_buf[8*r_cnt +: 8] <= i_rx_byte;
      end
    end

  // registered status pulses; transaction fields change only on a good frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_tr_valid <= 1'b0;
      o_crc_err <= 1'b0;
      o_frame_err <= 1'b0;
      o_tr_type <= '0;
      o_tr_data <= '0;
      o_tr_len <= '0;
    end else begin
      o_tr_valid <= w_ok;
      o_crc_err <= w_cerr;
      o_frame_err <= w_ferr;
      if (w_ok) begin
        o_tr_type <= r_type;
        o_tr_data <= r_state == LT_ETX ? (8*MAX_BYTES)'(r_lse) : w_payload;
        o_tr_len <= r_state == LT_ETX ? LW'(1) : LW'(r_cnt - CW'(2));
      end
    end
endmodule

// File: tb/tb_sb_rx_deframer.sv
// tb_sb_rx_deframer: directed and randomized frames checked against a frame-level model
module tb_sb_rx_deframer;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic tr_valid, crc_err, frame_err;
  logic [1:0] tr_type;
  logic [127:0] tr_data;
  logic [4:0] tr_len;
  int tests = 0, fails = 0, nv = 0, nc = 0, nf = 0;
  logic [1:0] m_type = 2'd0;
  logic [127:0] m_data = '0;
  logic [4:0] m_len = '0;

  always #5 clk = ~clk;

  sb_rx_deframer dut (
    .clk(clk), .rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_tr_valid(tr_valid), .o_tr_type(tr_type), .o_tr_data(tr_data), .o_tr_len(tr_len),
    .o_crc_err(crc_err), .o_frame_err(frame_err)
  );

  always @(posedge clk) begin
    #1;
    if (tr_valid) nv++;
    if (crc_err) nc++;
    if (frame_err) nf++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [15:0] ref_crc(input bq_t m);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (m[i])
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ m[i][k];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    return c;
  endfunction

  function automatic bq_t at_frame(input logic [7:0] stx, input bq_t pl, input int flip);
    bq_t msg, body, w;
    logic [15:0] c;
    msg = pl;
    msg.push_front(stx);
    c = ref_crc(msg);
    body = pl;
    body.push_back(c[15:8]);
    body.push_back(c[7:0]);
    if (flip >= 0) body[body.size() - 2 + flip / 8] ^= 8'(1 << (flip % 8));
    w.push_back(8'hFE);
    w.push_back(stx);
    foreach (body[i]) begin
      w.push_back(body[i]);
      if (body[i] == 8'hFE) w.push_back(8'hFE);
    end
    w.push_back(8'hFE);
    w.push_back(8'h40);
    return w;
  endfunction

  function automatic logic [127:0] pack(input bq_t pl);
    logic [127:0] d;
    d = '0;
    foreach (pl[i]) d[8*i +: 8] = pl[i];
    return d;
  endfunction

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte = b;
  endtask

  task automatic play(input string tag, input bq_t w, input logic ev, input logic ec, input logic ef,
                      input logic [1:0] et, input logic [127:0] ed, input logic [4:0] el);
    int v0, c0, f0;
    v0 = nv; c0 = nc; f0 = nf;
    foreach (w[i]) send(w[i]);
    @(negedge clk);
    rx_valid = 1'b0;
    if (ev) begin
      m_type = et; m_data = ed; m_len = el;
    end
    check({tag, ".valid"}, 128'(tr_valid), 128'(ev));
    check({tag, ".crc_err"}, 128'(crc_err), 128'(ec));
    check({tag, ".frame_err"}, 128'(frame_err), 128'(ef));
    check({tag, ".n_valid"}, 128'(nv - v0), 128'(ev));
    check({tag, ".n_crc"}, 128'(nc - c0), 128'(ec));
    check({tag, ".n_ferr"}, 128'(nf - f0), 128'(ef));
    check({tag, ".type"}, 128'(tr_type), 128'(m_type));
    check({tag, ".data"}, tr_data, m_data);
    check({tag, ".len"}, 128'(tr_len), 128'(m_len));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    m_type = '0; m_data = '0; m_len = '0;
    check("rst.valid", 128'(tr_valid), 128'(0));
    check("rst.data", tr_data, 128'(0));
    check("rst.len", 128'(tr_len), 128'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    bq_t w, pl;
    logic [7:0] lse, stx;
    int kind, pos, f0;
    repeat (3) @(negedge clk);
    check("reset.valid", 128'(tr_valid), 128'(0));
    check("reset.crc_err", 128'(crc_err), 128'(0));
    check("reset.frame_err", 128'(frame_err), 128'(0));
    check("reset.data", tr_data, 128'(0));
    check("reset.len", 128'(tr_len), 128'(0));
    check("reset.type", 128'(tr_type), 128'(0));
    rst_n = 1'b1;

    pl = {8'h11, 8'h22};
    play("at_cmd", at_frame(8'h05, pl, -1), 1, 0, 0, 2'd0, 128'h2211, 5'd2);
    pl = {8'hFE};
    play("stuff", at_frame(8'h04, pl, -1), 1, 0, 0, 2'd1, 128'hFE, 5'd1);
    w = {8'hFE, 8'h2A, 8'hD5, 8'hFE, 8'h40};
    play("lt_good", w, 1, 0, 0, 2'd2, 128'h2A, 5'd1);
    w = {8'hFE, 8'h2A, 8'hD4};
    play("lt_bad", w, 0, 0, 1, 2'd0, '0, '0);
    pl = {8'h33, 8'h44, 8'h55};
    play("crc_flip", at_frame(8'h05, pl, 8), 0, 1, 0, 2'd0, '0, '0);
    play("after_crc", at_frame(8'h05, pl, -1), 1, 0, 0, 2'd0, pack(pl), 5'd3);
    w = {8'hFE, 8'h05};
    for (int i = 0; i < 19; i++) w.push_back(8'(8'h10 + i));
    play("overflow", w, 0, 0, 1, 2'd0, '0, '0);
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'(8'hA0 + i));
    play("full16", at_frame(8'h04, pl, -1), 1, 0, 0, 2'd1, pack(pl), 5'd16);
    pl = {};
    play("empty", at_frame(8'h05, pl, -1), 1, 0, 0, 2'd0, '0, 5'd0);
    w = {8'hFE, 8'h05, 8'h11};
    play("mid_pre", w, 0, 0, 0, 2'd0, '0, '0);
    f0 = nf;
    pulse_reset();
    check("mid_rst.n_ferr", 128'(nf - f0), 128'(0));
    pl = {8'h77};
    play("after_rst", at_frame(8'h05, pl, -1), 1, 0, 0, 2'd0, 128'h77, 5'd1);

    for (int it = 0; it < 40; it++) begin
      w = {};
      repeat ($urandom_range(0, 2)) begin
        do lse = 8'($urandom); while (lse == 8'hFE);
        w.push_back(lse);
      end
      kind = int'($urandom_range(0, 3));
      do lse = 8'($urandom); while (lse == 8'hFE || lse == 8'h05 || lse == 8'h04);
      if (kind < 2) begin
        pl = {};
        repeat ($urandom_range(0, 16)) pl.push_back($urandom_range(0, 3) == 0 ? 8'hFE : 8'($urandom));
        stx = $urandom_range(0, 1) ? 8'h05 : 8'h04;
        w = {w, at_frame(stx, pl, kind == 1 ? int'($urandom_range(0, 15)) : -1)};
        play("rnd_at", w, kind == 0, kind == 1, 0, stx == 8'h05 ? 2'd0 : 2'd1, pack(pl), 5'(pl.size()));
      end else if (kind == 2) begin
        w = {w, 8'hFE, lse, ~lse, 8'hFE, 8'h40};
        play("rnd_lt", w, 1, 0, 0, 2'd2, 128'(lse), 5'd1);
      end else begin
        pl = {~lse, 8'hFE, 8'h40};
        pos = int'($urandom_range(0, 2));
        pl[pos] ^= 8'($urandom_range(1, 255));
        w.push_back(8'hFE);
        w.push_back(lse);
        for (int i = 0; i <= pos; i++) w.push_back(pl[i]);
        play("rnd_lt_bad", w, 0, 0, 1, 2'd0, '0, '0);
      end
    end

    w = {8'hFE, 8'h05, 8'h11};
    play("to_pre", w, 0, 0, 0, 2'd0, '0, '0);
    f0 = nf;
    repeat (1100) @(negedge clk);
`ifdef SB_TIMEOUT_EN
    check("timeout.n_ferr", 128'(nf - f0), 128'(1));
`else
    check("timeout.n_ferr", 128'(nf - f0), 128'(0));
`endif
    pulse_reset();
    pl = {8'h5A, 8'hFE, 8'h01};
    play("final", at_frame(8'h04, pl, -1), 1, 0, 0, 2'd1, pack(pl), 5'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
